// File: rtl/pam4_slicer_mer.sv
// 4-PAM slicer with adaptive threshold and block-averaged error power.
// Four-stage pipeline: capture/abs, decide/error, square, accumulate.
module pam4_slicer_mer #(
    parameter int unsigned      WIDTH        = 18,
    parameter int unsigned      ACC_LEN_LOG2 = 14,
    parameter logic [WIDTH-1:0] REF_INIT     = 18'd65536
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] x_in,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    output logic [WIDTH-1:0] ref_level,
    output logic [WIDTH-1:0] err_power,
    output logic             blk_done
);

    localparam int unsigned AW = WIDTH + ACC_LEN_LOG2;
    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH - 1){1'b0}}};

    // ---------------- Stage 1: capture and magnitude ----------------
    logic [WIDTH-1:0] abs_in;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] abs_r;
    logic             v1;

    always_comb begin
        abs_in = x_in;
        if (x_in == SMIN) begin
            abs_in = SMAX;
        end else if (x_in[WIDTH-1]) begin
            abs_in = -x_in;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            x_r   <= '0;
            abs_r <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= sym_clk_en;
            if (sym_clk_en) begin
                x_r   <= x_in;
                abs_r <= abs_in;
            end
        end
    end

    // ---------------- Stage 2: decision and error ----------------
    logic              neg;
    logic              outer;
    logic [EW-1:0]     ref_ext;
    logic [EW-1:0]     half_ext;
    logic [EW-1:0]     mag;
    logic [EW-1:0]     ideal;
    logic [EW-1:0]     x_ext;
    logic [EW-1:0]     diff;
    logic [WIDTH-1:0]  err_d;
    logic [1:0]        sym_d;

    logic [WIDTH-1:0]  err_r;
    logic [WIDTH-1:0]  abs2_r;
    logic              v2;

    always_comb begin
        neg      = x_r[WIDTH-1];
        outer    = abs_r > ref_level;
        ref_ext  = EW'(ref_level);
        half_ext = ref_ext >> 1;
        mag      = outer ? (ref_ext + half_ext) : half_ext;
        ideal    = neg ? -mag : mag;
        x_ext    = {{2{x_r[WIDTH-1]}}, x_r};
        diff     = x_ext - ideal;
        // Saturate when the bits above the 1s17 sign are not a pure sign extension.
        if (diff[EW-1:WIDTH-1] != {(EW - WIDTH + 1){diff[EW-1]}}) begin
            err_d = diff[EW-1] ? SMIN : SMAX;
        end else begin
            err_d = diff[WIDTH-1:0];
        end
        sym_d = {~neg, neg ? ~outer : outer};
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            err_r     <= '0;
            abs2_r    <= '0;
            v2        <= 1'b0;
        end else begin
            sym_valid <= v1;
            v2        <= v1;
            if (v1) begin
                sym_out <= sym_d;
                err_r   <= err_d;
                abs2_r  <= abs_r;
            end
        end
    end

    // ---------------- Stage 3: error squared ----------------
    logic signed [PW-1:0] sq;
    logic [WIDTH-1:0]     err_sq_r;
    logic [WIDTH-1:0]     abs3_r;
    logic                 v3;

    always_comb begin
        sq = $signed(err_r) * $signed(err_r);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            err_sq_r <= '0;
            abs3_r   <= '0;
            v3       <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                err_sq_r <= sq[PW-2:WIDTH-1];
                abs3_r   <= abs2_r;
            end
        end
    end

    // ---------------- Stage 4: block accumulation ----------------
    logic [AW-1:0]           abs_acc;
    logic [AW-1:0]           err_acc;
    logic [ACC_LEN_LOG2-1:0] sym_cnt;
    logic [AW-1:0]           abs_sum;
    logic [AW-1:0]           err_sum;
    logic [AW-1:0]           abs_mean;
    logic [AW-1:0]           err_mean;
    logic                    blk_end;

    always_comb begin
        abs_sum  = abs_acc + AW'(abs3_r);
        err_sum  = err_acc + AW'(err_sq_r);
        abs_mean = abs_sum >> ACC_LEN_LOG2;
        err_mean = err_sum >> ACC_LEN_LOG2;
        blk_end  = v3 && (sym_cnt == {ACC_LEN_LOG2{1'b1}});
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            abs_acc   <= '0;
            err_acc   <= '0;
            sym_cnt   <= '0;
            ref_level <= REF_INIT;
            err_power <= '0;
            blk_done  <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            // Clear beats both accumulation and block end on the same edge.
            if (acc_clr) begin
                abs_acc <= '0;
                err_acc <= '0;
                sym_cnt <= '0;
            end else if (blk_end) begin
                ref_level <= abs_mean[WIDTH-1:0];
                err_power <= err_mean[WIDTH-1:0];
                blk_done  <= 1'b1;
                abs_acc   <= '0;
                err_acc   <= '0;
                sym_cnt   <= '0;
            end else if (v3) begin
                abs_acc <= abs_sum;
                err_acc <= err_sum;
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    // Product sign/fraction bits and the mean's always-zero top bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{sq[PW-1], sq[WIDTH-2:0], abs_mean[AW-1:WIDTH], err_mean[AW-1:WIDTH]};

endmodule

// File: tb/tb_pam4_slicer_mer.sv
// Directed bench for pam4_slicer_mer with 4-symbol measurement blocks.
module tb_pam4_slicer_mer;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        sym_clk_en;
    logic        acc_clr;
    logic [17:0] x_in;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic [17:0] ref_level;
    logic [17:0] err_power;
    logic        blk_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    pam4_slicer_mer #(
        .WIDTH       (18),
        .ACC_LEN_LOG2(2),
        .REF_INIT    (18'd65536)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .sym_clk_en(sym_clk_en),
        .acc_clr   (acc_clr),
        .x_in      (x_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .ref_level (ref_level),
        .err_power (err_power),
        .blk_done  (blk_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One strobe, 4-cycle spacing; starts and ends on a falling edge.
    task automatic sym(input int x, input int exp_sym, input bit last, input bit clr);
        x_in       = 18'(x);
        sym_clk_en = 1'b1;
        @(negedge sys_clk);
        sym_clk_en = 1'b0;
        @(negedge sys_clk);
        check("sym_out", int'(sym_out), exp_sym);
        check("sym_valid_hi", int'(sym_valid), 1);
        @(negedge sys_clk);
        check("sym_valid_lo", int'(sym_valid), 0);
        if (clr) acc_clr = 1'b1;
        @(negedge sys_clk);
        acc_clr = 1'b0;
        if (!last) check("no_blk_done", int'(blk_done), 0);
    endtask

    task automatic blk(input string tag, input int exp_ref, input int exp_pow);
        check({tag, "_blk_done"}, int'(blk_done), 1);
        check({tag, "_ref"}, int'(ref_level), exp_ref);
        check({tag, "_pow"}, int'(err_power), exp_pow);
        @(negedge sys_clk);
        check({tag, "_blk_done_pulse"}, int'(blk_done), 0);
    endtask

    initial begin
        reset      = 1'b1;
        sym_clk_en = 1'b0;
        acc_clr    = 1'b0;
        x_in       = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_ref", int'(ref_level), 65536);
        check("rst_pow", int'(err_power), 0);
        check("rst_sym", int'(sym_out), 0);
        reset = 1'b0;
        @(negedge sys_clk);

        // Outer positive, zero error
        for (int i = 0; i < 4; i++) sym(98304, 3, i == 3, 1'b0);
        blk("outer", 98304, 0);

        // Inner at ref 98304: error 16384 -> err_sq 2048
        for (int i = 0; i < 4; i++) sym(65536, 2, i == 3, 1'b0);
        blk("inner", 65536, 2048);

        // Back-to-back alternating strobes
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                x_in       = (k % 2 == 0) ? 18'(98304) : 18'(-98304);
                sym_clk_en = 1'b1;
            end else begin
                sym_clk_en = 1'b0;
            end
            if (k >= 2 && k < 6) begin
                check("b2b_sym", int'(sym_out), (k % 2 == 0) ? 3 : 0);
                check("b2b_valid", int'(sym_valid), 1);
            end
            @(negedge sys_clk);
        end
        check("b2b_valid_lo", int'(sym_valid), 0);
        blk("b2b", 98304, 0);

        for (int i = 0; i < 4; i++) sym(65536, 2, i == 3, 1'b0);
        blk("inner2", 65536, 2048);

        // Mixed inner/equality/outer: err_sq 0, 399, 8192, 4975
        sym(32768, 2, 1'b0, 1'b0);
        sym(-40000, 1, 1'b0, 1'b0);
        sym(-65536, 1, 1'b0, 1'b0);
        sym(123840, 3, 1'b1, 1'b0);
        blk("mixed", 65536, 3391);

        // Negative full-scale saturates abs; zeros sit inner positive
        sym(-131072, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sym(0, 2, i == 2, 1'b0);
        blk("sat", 32767, 8192);

        for (int i = 0; i < 4; i++) sym(0, 2, i == 3, 1'b0);
        blk("zeros", 0, 2047);

        // ref 0: full-scale positive is outer, err_sq 131070
        for (int i = 0; i < 4; i++) sym(131071, 3, i == 3, 1'b0);
        blk("ref0", 131071, 131070);

        // acc_clr colliding with block end
        for (int i = 0; i < 4; i++) sym(0, 2, 1'b0, i == 3);
        check("clr_ref_hold", int'(ref_level), 131071);
        check("clr_pow_hold", int'(err_power), 131070);
        for (int i = 0; i < 4; i++) sym(0, 2, i == 3, 1'b0);
        blk("after_clr", 0, 32767);

        // Reset mid-block with a symbol in flight
        sym(98304, 3, 1'b0, 1'b0);
        sym(98304, 3, 1'b0, 1'b0);
        x_in       = 18'(98304);
        sym_clk_en = 1'b1;
        @(negedge sys_clk);
        sym_clk_en = 1'b0;
        reset      = 1'b1;
        @(negedge sys_clk);
        check("midrst_sym", int'(sym_out), 0);
        check("midrst_valid", int'(sym_valid), 0);
        check("midrst_ref", int'(ref_level), 65536);
        check("midrst_pow", int'(err_power), 0);
        check("midrst_blk", int'(blk_done), 0);
        reset = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 4; i++) sym(98304, 3, i == 3, 1'b0);
        blk("post_rst", 98304, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
